sync_ram: RTL and testbench

SYNC_RAM -- requirements
Module: sync_ram

---
 rtl/sync_ram_pkg.sv | 18 +
 rtl/sync_ram_lane.sv | 54 +++++
 rtl/sync_ram.sv | 50 +++++
 tb/tb_sync_ram.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg
//   Shared constants and types for the byte-strobed synchronous RAM.
//   SYNC_RAM_ADDR_WIDTH : default word-address width (depth = 2**width)
//   SYNC_RAM_DATA_WIDTH : default word width, a multiple of 8
//   byte_t              : one byte lane
package sync_ram_pkg;

   localparam int SYNC_RAM_ADDR_WIDTH = 8;
   localparam int SYNC_RAM_DATA_WIDTH = 32;

   typedef logic [7:0] byte_t;

   // Number of byte lanes in a word of the given width.
   function automatic int num_lanes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/sync_ram_lane.sv
// sync_ram_lane
//   One byte-wide, 2**ADDR_WIDTH-deep simple-dual-port bank with registered
//   read. When a read and a write hit the same word on the same edge, the read
//   returns the old contents (read-first).
//   Optional macro: SYNC_RAM_RESET_CLEAR_EN -- reset also zeroes the whole
//   bank in a single cycle. Without it, reset clears only the read register.
// Ports:
//   clock     rising-edge clock
//   reset     synchronous active-high reset
//   we_i      write enable for this lane
//   waddr_i   write word address
//   wdata_i   write byte
//   raddr_i   read word address
//   rdata_o   registered read byte
module sync_ram_lane
   import sync_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = SYNC_RAM_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  byte_t                 wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output byte_t                 rdata_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Power-up contents are zero so unwritten bytes read 0x00.
   byte_t mem_q [DEPTH] = '{default: '0};
   byte_t rdata_q;
   byte_t rdata_d;

   // Sampled from the pre-edge array contents, which gives read-first.
   assign rdata_d = reset ? '0 : mem_q[raddr_i];

   always_ff @(posedge clock) begin
      rdata_q <= rdata_d;
      if (reset) begin
`ifdef SYNC_RAM_RESET_CLEAR_EN
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`endif
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_ram.sv
// sync_ram
//   Synchronous RAM with independent read and write ports, per-byte write
//   strobes and one-cycle registered read. Built from NB = DATA_WIDTH/8
//   byte-wide banks, each lane enabled by its wstrb bit.
//   Optional macro: SYNC_RAM_RESET_CLEAR_EN -- reset zeroes all contents in a
//   single cycle; otherwise contents survive reset and only rdata clears.
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-high reset (rdata -> 0, writes suppressed)
//   raddr   read word address
//   waddr   write word address
//   wstrb   per-byte write enable, bit i covers wdata[8i+7:8i]
//   wdata   write data
//   rdata   registered read data
module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = SYNC_RAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = SYNC_RAM_DATA_WIDTH,
   localparam int NB        = DATA_WIDTH / 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [NB-1:0]         wstrb,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   for (genvar i = 0; i < NB; i++) begin : g_lane
      byte_t lane_rdata;

      // Reset gates the strobe in the lane itself, so no extra qualifier here.
      sync_ram_lane #(
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_lane (
         .clock   (clock),
         .reset   (reset),
         .we_i    (wstrb[i]),
         .waddr_i (waddr),
         .wdata_i (wdata[8*i +: 8]),
         .raddr_i (raddr),
         .rdata_o (lane_rdata)
      );

      assign rdata[8*i +: 8] = lane_rdata;
   end

endmodule

// File: tb/tb_sync_ram.sv
module tb_sync_ram;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int NB    = DW / 8;
   localparam int DEPTH = 2 ** AW;

   logic          clock;
   logic          reset;
   logic [AW-1:0] raddr;
   logic [AW-1:0] waddr;
   logic [NB-1:0] wstrb;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: a plain word array, read before write on every edge.
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] ref_rdata;

   sync_ram #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .raddr (raddr),
      .waddr (waddr),
      .wstrb (wstrb),
      .wdata (wdata),
      .rdata (rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, update the reference at the edge, check at negedge.
   task automatic step(input string tag, input logic rst, input logic [AW-1:0] ra,
                       input logic [AW-1:0] wa, input logic [NB-1:0] ws,
                       input logic [DW-1:0] wd);
      reset = rst;
      raddr = ra;
      waddr = wa;
      wstrb = ws;
      wdata = wd;
      @(posedge clock);
      if (rst) begin
         ref_rdata = '0;
`ifdef SYNC_RAM_RESET_CLEAR_EN
         for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
`endif
      end else begin
         ref_rdata = ref_mem[ra];
         for (int b = 0; b < NB; b++)
            if (ws[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
      end
      @(negedge clock);
      chk(tag, rdata, ref_rdata);
   endtask

   logic [DW-1:0] exp_word;

   initial begin
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
      reset = 1'b1;
      raddr = '0;
      waddr = '0;
      wstrb = '0;
      wdata = '0;

      // Reset for 10 cycles with a write attempt that must be suppressed.
      for (int c = 0; c < 10; c++) step("reset_rdata", 1'b1, 8'd0, 8'd9, 4'hF, 32'hCAFEF00D);
      step("word9_after_rst", 1'b0, 8'd9, 8'd0, 4'h0, 32'h0);
      step("unwritten_zero", 1'b0, 8'd7, 8'd0, 4'h0, 32'h0);

      // Full write then read.
      step("wr0", 1'b0, 8'd0, 8'd0, 4'hF, 32'hDEADBEEF);
      step("rd0_full", 1'b0, 8'd0, 8'd0, 4'h0, 32'h0);
      exp_word = 32'hDEADBEEF;
      chk("rd0_const", rdata, exp_word);

      // Partial strobes.
      step("wr1", 1'b0, 8'd0, 8'd1, 4'h3, 32'hDEADBEEF);
      step("rd1_lo", 1'b0, 8'd1, 8'd2, 4'hC, 32'hDEADBEEF);
      exp_word = 32'h0000BEEF;
      chk("rd1_const", rdata, exp_word);
      step("rd2_hi", 1'b0, 8'd2, 8'd3, 4'h1, 32'hDEADBEEF);
      exp_word = 32'hDEAD0000;
      chk("rd2_const", rdata, exp_word);
      step("rd3_b0", 1'b0, 8'd3, 8'd4, 4'h2, 32'hDEADBEEF);
      exp_word = 32'h000000EF;
      chk("rd3_const", rdata, exp_word);
      step("rd4_b1", 1'b0, 8'd4, 8'd0, 4'h0, 32'h0);
      exp_word = 32'h0000BE00;
      chk("rd4_const", rdata, exp_word);

      // Read-first collision.
      step("wr5", 1'b0, 8'd0, 8'd5, 4'hF, 32'h11111111);
      step("collide5", 1'b0, 8'd5, 8'd5, 4'hF, 32'h22222222);
      exp_word = 32'h11111111;
      chk("collide_old", rdata, exp_word);
      step("after_collide5", 1'b0, 8'd5, 8'd0, 4'h0, 32'h0);
      exp_word = 32'h22222222;
      chk("collide_new", rdata, exp_word);

      // Zero strobe leaves memory untouched.
      step("nostrb", 1'b0, 8'd1, 8'd0, 4'h0, 32'hFFFFFFFF);
      step("rd0_nostrb", 1'b0, 8'd0, 8'd0, 4'h0, 32'h0);
      exp_word = 32'hDEADBEEF;
      chk("nostrb_const", rdata, exp_word);

      // Address extremes, independent ports in the same cycle.
      step("wr_top", 1'b0, 8'd0, 8'd255, 4'hF, 32'hA5A55A5A);
      step("rd_top_wr_bot", 1'b0, 8'd255, 8'd6, 4'hF, 32'h01234567);
      step("rd_bot", 1'b0, 8'd6, 8'd0, 4'h0, 32'h0);

      // Mid-operation single-cycle reset; word 0 survives unless clearing is built in.
      step("mid_reset", 1'b1, 8'd0, 8'd0, 4'hF, 32'h0BADF00D);
      step("rd0_after_rst", 1'b0, 8'd0, 8'd0, 4'h0, 32'h0);
`ifdef SYNC_RAM_RESET_CLEAR_EN
      exp_word = 32'h0;
`else
      exp_word = 32'hDEADBEEF;
`endif
      chk("rst_keep_const", rdata, exp_word);
      step("rd_top_after_rst", 1'b0, 8'd255, 8'd0, 4'h0, 32'h0);

      // Randomized traffic, concentrated on a few addresses to force collisions.
      for (int n = 0; n < 600; n++) begin
         logic          rr;
         logic [AW-1:0] ra, wa;
         rr = ($urandom_range(0, 79) == 0);
         ra = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                          : AW'($urandom_range(0, 7));
         wa = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                          : AW'($urandom_range(0, 7));
         step("rand", rr, ra, wa, NB'($urandom_range(0, 15)), DW'($urandom));
      end

      // Sweep the whole array back against the reference.
      for (int a = 0; a < DEPTH; a++) step("sweep", 1'b0, AW'(a), 8'd0, 4'h0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
